// File: rtl/servo_cmd_ramp_if.sv
// APB3 bus bundle for the servo command ramp block.
interface servo_cmd_ramp_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/servo_cmd_ramp.sv
// Servo pulse-width command: clamps the firmware target and slews the applied
// width toward it by at most STEP counts per PWM frame.
module servo_cmd_ramp #(
  parameter int unsigned PERIOD       = 2000000,
  parameter int unsigned PW_MIN       = 100000,
  parameter int unsigned PW_MAX       = 200000,
  parameter int unsigned PW_INIT      = 150000,
  parameter int unsigned STEP_DEFAULT = 500
) (
  input  logic                    PCLK,
  input  logic                    PRESERN,
  servo_cmd_ramp_if.slave         apb,
  output logic [31:0]             pulse_width,
  output logic                    pw_update,
  output logic                    frame_tick,
  output logic                    at_target
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [31:0]   PMIN  = PW_MIN;
  localparam logic [31:0]   PMAX  = PW_MAX;
  localparam logic [31:0]   PINIT = PW_INIT;
  localparam logic [31:0]   PSTEP = STEP_DEFAULT;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0] target, current, step, cur_nxt, delta, wr_clamped;
  logic        en, en_nxt, clamped, clamp_hit;
  logic        wr, wr_tgt, wr_step, wr_ctrl;
  logic        unused_addr;

  assign wr      = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wr_tgt  = wr && (apb.PADDR[3:2] == 2'd0);
  assign wr_step = wr && (apb.PADDR[3:2] == 2'd1);
  assign wr_ctrl = wr && (apb.PADDR[3:2] == 2'd3);
  assign en_nxt  = wr_ctrl ? apb.PWDATA[0] : en;
  assign unused_addr = ^{apb.PADDR[31:4], apb.PADDR[1:0]};

  assign frame_tick  = (cnt == LAST);
  assign at_target   = (current == target);
  assign pulse_width = current;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  always_comb begin
    wr_clamped = apb.PWDATA;
    clamp_hit  = 1'b0;
    if (apb.PWDATA < PMIN) begin
      wr_clamped = PMIN;
      clamp_hit  = 1'b1;
    end else if (apb.PWDATA > PMAX) begin
      wr_clamped = PMAX;
      clamp_hit  = 1'b1;
    end
  end

  always_comb begin
    apb.PRDATA = 32'd0;
    if (apb.PSEL) begin
      case (apb.PADDR[3:2])
        2'd0:    apb.PRDATA = target;
        2'd1:    apb.PRDATA = step;
        2'd2:    apb.PRDATA = current;
        default: apb.PRDATA = {29'd0, clamped, at_target, en};
      endcase
    end
  end

  // Direction comes from the compare, never from a signed difference.
  always_comb begin
    state_nxt = state;
    cur_nxt   = current;
    delta     = (target >= current) ? (target - current) : (current - target);
    case (state)
      IDLE: state_nxt = (current != target) ? RAMP : HOLD;
      RAMP: begin
        if (frame_tick) begin
          if ((step == 32'd0) || (delta <= step)) begin
            cur_nxt   = target;
            state_nxt = HOLD;
          end else if (target > current) begin
            cur_nxt = current + step;
          end else begin
            cur_nxt = current - step;
          end
        end
      end
      HOLD: if (current != target) state_nxt = RAMP;
      default: state_nxt = IDLE;
    endcase
    // Clearing EN, even on the tick cycle itself, freezes CURRENT where it is.
    if (!en_nxt) begin
      state_nxt = IDLE;
      cur_nxt   = current;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= PINIT;
      current   <= PINIT;
      step      <= PSTEP;
      en        <= 1'b0;
      clamped   <= 1'b0;
      pw_update <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= frame_tick ? '0 : cnt + CW'(1);
      current   <= cur_nxt;
      pw_update <= (cur_nxt != current);
      en        <= en_nxt;
      if (wr_tgt)  target <= wr_clamped;
      if (wr_step) step   <= apb.PWDATA;
      if (wr_tgt && clamp_hit)
        clamped <= 1'b1;
      else if (wr_ctrl && apb.PWDATA[2])
        clamped <= 1'b0;
    end
  end
endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Directed bench for servo_cmd_ramp with a short simulation frame.
module tb_servo_cmd_ramp;
  logic        PCLK, PRESERN;
  logic [31:0] pulse_width;
  logic        pw_update, frame_tick, at_target;
  int          errors = 0, checks = 0, upd_cnt = 0;

  servo_cmd_ramp_if bus();

  servo_cmd_ramp #(.PERIOD(100)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .apb(bus),
    .pulse_width(pulse_width), .pw_update(pw_update),
    .frame_tick(frame_tick), .at_target(at_target)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) if (pw_update === 1'b1) upd_cnt++;

  typedef struct {
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input bit on_tick);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    if (on_tick) chk("tick_align", {31'd0, frame_tick}, 32'd1);
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 d = bus.PRDATA;
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge of the next tick cycle.
  task automatic wait_tick(input string name);
    bit seen = 0;
    for (int i = 0; i < 250 && !seen; i++) begin
      if (frame_tick) seen = 1;
      else @(negedge PCLK);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no frame_tick within 250 cycles", name);
    end
  endtask

  task automatic step_chk(input string name, input logic [31:0] exp, input logic exp_upd);
    wait_tick(name);
    @(negedge PCLK);
    chk(name, pulse_width, exp);
    chk({name, "_upd"}, {31'd0, pw_update}, {31'd0, exp_upd});
  endtask

  initial begin
    logic [31:0] rd;
    int n, base;

    tbl[0]  = '{0, 32'h0,  32'd0,      32'h0, 32'd150000, "rst_target"};
    tbl[1]  = '{0, 32'h0,  32'd0,      32'h4, 32'd500,    "rst_step"};
    tbl[2]  = '{0, 32'h0,  32'd0,      32'h8, 32'd150000, "rst_current"};
    tbl[3]  = '{0, 32'h0,  32'd0,      32'hC, 32'h2,      "rst_ctrl"};
    tbl[4]  = '{1, 32'h0,  32'd250000, 32'h0, 32'd200000, "clamp_hi"};
    tbl[5]  = '{0, 32'h0,  32'd0,      32'hC, 32'h4,      "clamp_hi_flag"};
    tbl[6]  = '{1, 32'hC,  32'h4,      32'hC, 32'h0,      "w1c_clear"};
    tbl[7]  = '{1, 32'h0,  32'd50000,  32'h0, 32'd100000, "clamp_lo"};
    tbl[8]  = '{0, 32'h0,  32'd0,      32'hC, 32'h4,      "clamp_lo_flag"};
    tbl[9]  = '{1, 32'hC,  32'h4,      32'hC, 32'h0,      "w1c_clear2"};
    tbl[10] = '{1, 32'h8,  32'd12345,  32'h8, 32'd150000, "current_ro"};
    tbl[11] = '{1, 32'h0,  32'd175000, 32'h0, 32'd175000, "target_mid"};
    tbl[12] = '{0, 32'h0,  32'd0,      32'hC, 32'h0,      "mid_noflag"};
    tbl[13] = '{1, 32'h10, 32'd150000, 32'h0, 32'd150000, "alias_write"};
    tbl[14] = '{0, 32'h0,  32'd0,      32'h1C, 32'h2,     "alias_ctrl"};
    tbl[15] = '{1, 32'h4,  32'd1000,   32'h4, 32'd1000,   "step_rw"};
    tbl[16] = '{1, 32'h0,  32'd100000, 32'hC, 32'h0,      "edge_min_noflag"};
    tbl[17] = '{1, 32'h0,  32'd200000, 32'h0, 32'd200000, "edge_max"};
    tbl[18] = '{0, 32'h0,  32'd0,      32'hC, 32'h0,      "edge_max_noflag"};
    tbl[19] = '{1, 32'h0,  32'd150000, 32'hC, 32'h2,      "back_neutral"};
    tbl[20] = '{1, 32'h4,  32'd500,    32'h4, 32'd500,    "step_restore"};

    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    PRESERN = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    #1;
    chk("rst_pw", pulse_width, 32'd150000);
    chk("rst_at_target", {31'd0, at_target}, 32'd1);
    chk("rst_pw_update", {31'd0, pw_update}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("pready", {31'd0, bus.PREADY}, 32'd1);
    chk("pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    chk("prdata_nosel", bus.PRDATA, 32'd0);

    // Counter starts at 0 on release, so the first tick is 99 cycles later.
    n = 0;
    while (!frame_tick && n < 300) begin @(negedge PCLK); n++; end
    chk("first_tick", n, 99);
    n = 0;
    do begin @(negedge PCLK); n++; end while (!frame_tick && n < 300);
    chk("tick_period", n, 100);

    base = upd_cnt;
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].do_wr) apb_wr(tbl[i].waddr, tbl[i].wdata, 0);
      apb_rd(tbl[i].raddr, rd);
      chk(tbl[i].name, rd, tbl[i].exp);
    end
    chk("idle_no_update", upd_cnt - base, 0);

    // Basic ramp up with three steps.
    apb_wr(32'h0, 32'd151200, 0);
    apb_wr(32'hC, 32'h1, 0);
    base = upd_cnt;
    step_chk("up1", 32'd150500, 1'b1);
    step_chk("up2", 32'd151000, 1'b1);
    step_chk("up3", 32'd151200, 1'b1);
    chk("up_at_target", {31'd0, at_target}, 32'd1);
    step_chk("up_hold", 32'd151200, 1'b0);
    chk("up_upd_count", upd_cnt - base, 3);
    apb_rd(32'hC, rd);
    chk("up_ctrl", rd, 32'h3);

    // STEP = 0 jumps in one frame.
    apb_wr(32'h4, 32'd0, 0);
    apb_wr(32'h0, 32'd150000, 0);
    step_chk("jump0", 32'd150000, 1'b1);

    // Ramp down, pause with EN = 0, resume.
    apb_wr(32'h4, 32'd1000, 0);
    apb_wr(32'h0, 32'd140000, 0);
    step_chk("dn1", 32'd149000, 1'b1);
    step_chk("dn2", 32'd148000, 1'b1);
    step_chk("dn3", 32'd147000, 1'b1);
    apb_wr(32'hC, 32'h0, 0);
    base = upd_cnt;
    step_chk("pause1", 32'd147000, 1'b0);
    step_chk("pause2", 32'd147000, 1'b0);
    chk("pause_upd_count", upd_cnt - base, 0);
    apb_rd(32'hC, rd);
    chk("pause_ctrl", rd, 32'h0);
    apb_wr(32'hC, 32'h1, 0);
    step_chk("resume1", 32'd146000, 1'b1);
    step_chk("resume2", 32'd145000, 1'b1);

    // Target write on the tick cycle: this step still heads to 140000.
    repeat (98) @(negedge PCLK);
    apb_wr(32'h0, 32'd160000, 1);
    chk("tick_wr_old", pulse_width, 32'd144000);
    chk("tick_wr_old_upd", {31'd0, pw_update}, 32'd1);
    step_chk("tick_wr_new", 32'd145000, 1'b1);

    // EN cleared on the tick cycle: no step.
    repeat (98) @(negedge PCLK);
    apb_wr(32'hC, 32'h0, 1);
    chk("tick_dis", pulse_width, 32'd145000);
    chk("tick_dis_upd", {31'd0, pw_update}, 32'd0);
    step_chk("tick_dis_hold", 32'd145000, 1'b0);
    apb_wr(32'hC, 32'h1, 0);
    step_chk("tick_dis_resume", 32'd146000, 1'b1);

    apb_wr(32'h4, 32'd0, 0);
    apb_wr(32'h0, 32'd190000, 0);
    step_chk("jump0_big", 32'd190000, 1'b1);
    chk("jump0_at_target", {31'd0, at_target}, 32'd1);

    // Asynchronous reset mid-ramp, asserted and released between edges.
    apb_wr(32'h4, 32'd1000, 0);
    apb_wr(32'h0, 32'd100000, 0);
    step_chk("pre_rst", 32'd189000, 1'b1);
    #2 PRESERN = 1'b0;
    #1;
    chk("arst_pw", pulse_width, 32'd150000);
    chk("arst_at_target", {31'd0, at_target}, 32'd1);
    chk("arst_frame_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    #1 PRESERN = 1'b1;
    n = 0;
    while (!frame_tick && n < 300) begin @(negedge PCLK); n++; end
    chk("arst_counter_restart", n, 99);
    chk("arst_pw_hold", pulse_width, 32'd150000);
    apb_rd(32'hC, rd);
    chk("arst_ctrl", rd, 32'h2);
    apb_rd(32'h4, rd);
    chk("arst_step", rd, 32'd500);
    apb_rd(32'h0, rd);
    chk("arst_target", rd, 32'd150000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/servo_cmd_ramp.md
Name: servo_cmd_ramp

Overview:
APB3 slave that sits directly upstream of the servo PWM generator and supplies its pulse-width word. Firmware writes a target pulse width. The block clamps it to safe servo limits and slews the applied pulse width toward the target by at most STEP counts once per PWM frame. This prevents step changes in wheel command that would jolt the balancing loop. The block presents `pulse_width` plus a one-cycle `pw_update` strobe for the PWM stage to capture.

Parameters:
PERIOD, 2000000, PCLK cycles per PWM frame (20 ms at 100 MHz); must match the PWM stage.
PW_MIN, 100000, lowest legal pulse width (1.0 ms).
PW_MAX, 200000, highest legal pulse width (2.0 ms).
PW_INIT, 150000, reset and neutral pulse width (1.5 ms, servo stopped).
STEP_DEFAULT, 500, reset value of the STEP register.

Ports:
PCLK  in  1  system clock
PRESERN  in  1  reset, asynchronous, active-low
PSEL  in  1  APB peripheral select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  32  APB address; only [3:2] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1 (zero wait states)
PSLVERR  out  1  tied 0
pulse_width  out  32  applied pulse width in PCLK counts, to PWM stage
pw_update  out  1  one-cycle strobe: pulse_width changed this cycle
frame_tick  out  1  one-cycle strobe at the end of each frame
at_target  out  1  high when CURRENT == TARGET

Behaviour:
- Reset:
  - Asynchronous on PRESERN low; all state clears immediately.
  - TARGET = CURRENT = pulse_width = PW_INIT; STEP = STEP_DEFAULT; EN = 0; CLAMPED = 0.
  - frame counter = 0; pw_update = 0; frame_tick = 0; at_target = 1.
  - State = IDLE.
- Register map (write commits on PSEL & PENABLE & PWRITE, one PCLK edge):
  - 0x0 TARGET (rw): written value clamped to [PW_MIN, PW_MAX]. If clamping occurred, CLAMPED is set.
  - 0x4 STEP (rw): 32-bit. STEP = 0 means jump to TARGET in one frame.
  - 0x8 CURRENT (ro): writes ignored.
  - 0xC CTRL (mixed): bit0 EN (rw); bit1 at_target (ro); bit2 CLAMPED (sticky, write-1-to-clear); other bits read 0.
- Reads:
  - PRDATA is combinational from PADDR[3:2] whenever PSEL is high, otherwise 0.
  - Undecoded upper address bits are ignored (aliasing).
- Frame counter:
  - Counts 0..PERIOD-1, then wraps to 0; free-running regardless of EN.
  - frame_tick is high for exactly the one cycle where counter == PERIOD-1.
- State machine, evaluated every cycle:
  - IDLE (EN = 0): CURRENT frozen.
    - EN = 1 and CURRENT != TARGET → RAMP.
    - EN = 1 and CURRENT == TARGET → HOLD.
  - RAMP: on frame_tick, d = |TARGET - CURRENT|.
    - If STEP == 0 or d <= STEP: CURRENT <= TARGET, then go to HOLD.
    - Otherwise CURRENT moves STEP counts toward TARGET.
  - HOLD: a TARGET write that differs from CURRENT → RAMP.
  - Any state with EN = 0 → IDLE. A ramp in progress freezes at its present CURRENT and does not snap to TARGET.
- Latency and strobes:
  - CURRENT, pulse_width and pw_update all change on the edge following the frame_tick cycle (tick in cycle N, new value and pw_update = 1 in cycle N+1).
  - pw_update is asserted only when the value actually changes.
  - pulse_width always equals CURRENT.
- Simultaneous events:
  - TARGET write in the same cycle as frame_tick: that frame's step uses the old TARGET; the new TARGET takes effect at the next tick.
  - EN cleared in the same cycle as frame_tick: no step is taken.
  - W1C of CLAMPED in the same cycle as a new out-of-range TARGET write: set wins.
- Arithmetic:
  - All values are unsigned 32-bit.
  - CURRENT and TARGET always stay within [PW_MIN, PW_MAX], so no wrap-around occurs.
  - Direction is decided by comparison, not by signed subtraction.
- Reset mid-ramp: CURRENT returns to PW_INIT immediately. The PWM stage sees neutral at its next capture.

Test Plan:
1. Reset with PERIOD = 100 in sim → read 0x0 = 0x8 = 150000, 0x4 = 500, CTRL = 0x2, pulse_width = 150000, frame_tick every 100 cycles.
2. EN = 1, STEP = 500, TARGET = 151200 → CURRENT = 150500, then 151000, then 151200 on three successive ticks; at_target = 1 after the third; exactly three pw_update pulses.
3. TARGET = 250000 → reads back 200000, CTRL bit2 = 1; write 0x4 to CTRL → bit2 clears; TARGET = 50000 → reads back 100000, bit2 = 1.
4. Ramp down from 150000 to 140000 with STEP = 1000; clear EN after 3 ticks → CURRENT holds at 147000 with no pw_update; re-set EN → ramp resumes 146000, 145000, and so on.
5. TARGET write landing exactly on a frame_tick cycle → that step uses the old target; the next step heads toward the new target. STEP = 0 → CURRENT equals TARGET after one tick.
6. Assert PRESERN low asynchronously mid-ramp, off-edge → pulse_width = 150000 and at_target = 1 before the next PCLK edge; counter restarts from 0.
